irq_input_conditioner: RTL
==========================

Name: irq_input_conditioner

Overview:
- Upstream stage of the interrupt controller; its output drives the controller's irq_trigger input directly.
- Synchronises asynchronous raw interrupt lines into the pclk domain and debounces each line.
- Per line, converts the debounced level into a one-cycle trigger pulse (rising, falling or both edges) or a level request.
- Reports per-line glitches through sticky flags.

Parameters:
- NUM_IRQ, 4, number of interrupt lines.
- SYNC_STAGES, 2, synchroniser depth; legal values are 2 and up.
- DEBOUNCE_W, 4, width of the debounce threshold and of each per-line counter.

Ports:
- pclk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  clock-gating enable; all state holds when low.
- irq_raw_i  in  NUM_IRQ  asynchronous raw interrupt lines.
- edge_sel_i  in  2*NUM_IRQ  per-line mode, bits [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 level.
- debounce_i  in  DEBOUNCE_W  stability threshold D shared by all lines; 0 disables debounce.
- glitch_clr_i  in  NUM_IRQ  per-line one-cycle clear of the glitch flag.
- irq_trigger_o  out  NUM_IRQ  to the interrupt controller: one-cycle pulse (edge modes) or level (mode 11).
- irq_level_o  out  NUM_IRQ  debounced stable level per line.
- glitch_o  out  NUM_IRQ  sticky flag: a change reverted before debounce completed.

Behaviour:
Reset (async, rst_n_i=0):
- Synchroniser flops, stable level s, counters and FSMs cleared; all outputs 0.
- Assertion at any time aborts pending candidates; no pulse is generated on release.

Synchroniser:
- SYNC_STAGES flops per line; x = last stage.
- Only x is used downstream; irq_raw_i is never used combinationally.

Per-line FSM (states STABLE, CANDIDATE):
- STABLE, x==s: stay, cnt=0.
- STABLE, x!=s, D=0: commit at this edge (s<=x).
- STABLE, x!=s, D>0: go to CANDIDATE, cnt<=1.
- CANDIDATE, x!=s, cnt==D: commit, go to STABLE, cnt<=0.
- CANDIDATE, x!=s, cnt<D: cnt<=cnt+1.
- CANDIDATE, x==s: back to STABLE, cnt<=0, glitch_o[i]<=1.
- Net effect: commit happens on the (D+1)-th consecutive edge with x!=s.
- cnt is DEBOUNCE_W wide and never wraps, because it stops at D.
- D is sampled every cycle; lowering D below the current cnt commits on the next edge with x!=s (compare is cnt>=D).

Commit and outputs:
- irq_level_o = s, registered.
- Edge pulse registered at the commit edge; high exactly one cycle.
- Rising: s 0->1. Falling: s 1->0. Both: either direction.
- Level mode: irq_trigger_o[i] = s, registered, updated every edge.
- Latency: raw change stable before sampling edge 1 -> irq_level_o and pulse valid after edge SYNC_STAGES+D+1 (edge 3 with defaults and D=0).

Mode changes:
- edge_sel_i change takes effect at the next edge.
- A mode change alone never creates an edge pulse.
- Switching to level mode immediately reflects s.

Glitch flags:
- glitch_o[i] sets as defined in the FSM.
- Cleared by glitch_clr_i[i] at an edge; set wins if both occur at the same edge.

enable_i=0:
- Synchronisers, FSMs, counters, s and glitch flags hold.
- Edge-pulse registers clear to 0 at the next edge; a pending pulse is not replayed.
- Level-mode outputs hold.
- After re-enable, processing resumes from the held state.

Lines are fully independent:
- Simultaneous events on several lines produce simultaneous pulses in the same cycle.

Test Plan:
- Reset, defaults, D=0, mode rising; irq_raw_i 0000->1100 before edge 1 -> irq_trigger_o=1100 for exactly one cycle after edge 3; irq_level_o=1100 stays.
- D=3, mode both, line0: 0->1 held 10 cycles then 1->0 -> two single pulses, each 6 edges after the raw change; glitch_o=0.
- D=3, line1 high for 2 cycles only -> no pulse; irq_level_o[1]=0; glitch_o[1]=1 until glitch_clr_i[1]; clear and set at the same edge leaves it 1.
- Mode level on line2, D=0; raw high 5 cycles -> irq_trigger_o[2] high for 5 cycles, 3-cycle latency on both edges.
- enable_i=0 for 4 cycles spanning a raw rise on line3 -> no output change while low; the event completes after re-enable and the pulse appears once, 3 edges later.
- rst_n_i asserted mid-CANDIDATE (D=5, cnt=3) -> all outputs 0 immediately; raw high at release -> pulse after SYNC_STAGES+D+1 edges from release.

Source files
------------

// File: rtl/irq_input_conditioner.sv
// irq_input_conditioner
// Front end of the interrupt controller: synchronises raw interrupt lines,
// debounces each line against a shared threshold, and turns the debounced
// level into a one-cycle edge pulse or a level request. Reverted changes are
// reported through sticky per-line glitch flags.
module irq_input_conditioner #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 4
) (
  input  logic                  pclk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic [NUM_IRQ-1:0]    irq_raw_i,
  input  logic [2*NUM_IRQ-1:0]  edge_sel_i,
  input  logic [DEBOUNCE_W-1:0] debounce_i,
  input  logic [NUM_IRQ-1:0]    glitch_clr_i,
  output logic [NUM_IRQ-1:0]    irq_trigger_o,
  output logic [NUM_IRQ-1:0]    irq_level_o,
  output logic [NUM_IRQ-1:0]    glitch_o
);

  typedef enum logic {
    ST_STABLE    = 1'b0,
    ST_CANDIDATE = 1'b1
  } deb_state_e;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  // Synchroniser chain, one vector per stage; stage 0 samples the raw lines.
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_x;

  assign sync_x = sync_q[SYNC_STAGES-1];

  // Shift the synchroniser only while enabled so a held line is not lost.
  always_comb begin
    sync_d = sync_q;
    if (enable_i) begin
      sync_d[0] = irq_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end
  end

  // Synchroniser register.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    deb_state_e            state_q, state_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  s_q, s_d;
    logic                  glitch_q, glitch_d;
    logic                  trig_q, trig_d;
    logic                  commit;
    logic [1:0]            mode;

    assign mode = edge_sel_i[2*gi +: 2];

    // Debounce FSM: a change must persist for D+1 consecutive edges before
    // it is committed to the stable level; an early revert flags a glitch.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      s_d      = s_q;
      glitch_d = glitch_q;
      commit   = 1'b0;
      if (enable_i) begin
        if (glitch_clr_i[gi]) begin
          glitch_d = 1'b0;
        end
        case (state_q)
          ST_STABLE: begin
            if (sync_x[gi] != s_q) begin
              if (debounce_i == '0) begin
                commit = 1'b1;
              end else begin
                state_d = ST_CANDIDATE;
                cnt_d   = DEBOUNCE_W'(1);
              end
            end else begin
              cnt_d = '0;
            end
          end
          ST_CANDIDATE: begin
            if (sync_x[gi] == s_q) begin
              state_d  = ST_STABLE;
              cnt_d    = '0;
              glitch_d = 1'b1;
            end else if (cnt_q >= debounce_i) begin
              // >= so that lowering D mid-candidate commits promptly.
              commit = 1'b1;
            end else begin
              cnt_d = cnt_q + DEBOUNCE_W'(1);
            end
          end
          default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        endcase
        if (commit) begin
          s_d     = sync_x[gi];
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end
    end

    // Trigger: level mode follows the new stable level (held while disabled);
    // edge modes pulse only on a commit in the selected direction.
    always_comb begin
      trig_d = 1'b0;
      if (mode == MODE_LEVEL) begin
        trig_d = enable_i ? s_d : trig_q;
      end else if (enable_i) begin
        case (mode)
          MODE_RISE: trig_d = commit & s_d;
          MODE_FALL: trig_d = commit & ~s_d;
          MODE_BOTH: trig_d = commit;
          default:   trig_d = 1'b0;
        endcase
      end
    end

    // Per-line state and output registers.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q  <= ST_STABLE;
        cnt_q    <= '0;
        s_q      <= 1'b0;
        glitch_q <= 1'b0;
        trig_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        s_q      <= s_d;
        glitch_q <= glitch_d;
        trig_q   <= trig_d;
      end
    end

    assign irq_level_o[gi]   = s_q;
    assign irq_trigger_o[gi] = trig_q;
    assign glitch_o[gi]      = glitch_q;
  end

endmodule
